// File: rtl/mem_loader_pkg.sv
// Shared definitions for the UART-driven data memory loader: frame field order,
// FSM state encoding and the default frame start byte.
package mem_loader_pkg;

  localparam int FLD_SYNC    = 0;
  localparam int FLD_ADDR_LO = 1;
  localparam int FLD_ADDR_HI = 2;
  localparam int FLD_CNT_LO  = 3;
  localparam int FLD_CNT_HI  = 4;
  localparam int FLD_DATA_LO = 5;
  localparam int FLD_DATA_HI = 6;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Each state waits for the frame field of the same index.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'(FLD_SYNC),
    ST_ADDR_LO = 3'(FLD_ADDR_LO),
    ST_ADDR_HI = 3'(FLD_ADDR_HI),
    ST_CNT_LO  = 3'(FLD_CNT_LO),
    ST_CNT_HI  = 3'(FLD_CNT_HI),
    ST_DATA_LO = 3'(FLD_DATA_LO),
    ST_DATA_HI = 3'(FLD_DATA_HI)
  } state_t;

endpackage

// File: rtl/mem_loader_byte_timeout_counter.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and flags
// the cycle on which TIMEOUT idle cycles have elapsed.
module byte_timeout_counter #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Fires on the edge that would bring the count up to TIMEOUT.
  assign expired = en && !clr && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Decodes framed load commands from the UART byte stream and writes the words
// into data memory, stalling the core via hold while a frame is in progress.
//
// state      | meaning
// IDLE       | waiting for SYNC, other bytes dropped
// ADDR_LO    | waiting for base address low byte
// ADDR_HI    | waiting for base address high byte
// CNT_LO     | waiting for word count low byte
// CNT_HI     | waiting for word count high byte
// DATA_LO    | waiting for data word low byte
// DATA_HI    | waiting for data word high byte, issues the write
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int         N       = 12,
  parameter int         TIMEOUT = 100000,
  parameter logic [7:0] SYNC    = SYNC_BYTE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         mem_write_en,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_datain,
  output logic         hold,
  output logic         done,
  output logic         err,
  output logic [N-1:0] words_written
);

  state_t         state, state_n;
  logic [N-1:0]   cur_addr, cur_addr_n;
  logic [N-1:0]   remaining, remaining_n;
  logic [7:0]     lo_byte, lo_byte_n;
  logic           fin_pend, fin_pend_n;
  logic           write_en_n, hold_n, done_n, err_n;
  logic [N-1:0]   addr_n, datain_n, words_n;
  logic [N-1:0]   field;
  logic           expired;

  byte_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rx_valid || (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  // lo_byte holds the low half of whichever 16-bit field is being assembled.
  assign field = N'({rx_data, lo_byte});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      lo_byte       <= '0;
      fin_pend      <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_addr      <= '0;
      mem_datain    <= '0;
      hold          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      state         <= state_n;
      cur_addr      <= cur_addr_n;
      remaining     <= remaining_n;
      lo_byte       <= lo_byte_n;
      fin_pend      <= fin_pend_n;
      mem_write_en  <= write_en_n;
      mem_addr      <= addr_n;
      mem_datain    <= datain_n;
      hold          <= hold_n;
      done          <= done_n;
      err           <= err_n;
      words_written <= words_n;
    end
  end

  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    remaining_n = remaining;
    lo_byte_n   = lo_byte;
    fin_pend_n  = 1'b0;
    write_en_n  = 1'b0;
    addr_n      = mem_addr;
    datain_n    = mem_datain;
    hold_n      = hold;
    done_n      = 1'b0;
    err_n       = err;
    words_n     = words_written;

    // Completion is reported one cycle after the last write strobe.
    if (fin_pend) begin
      done_n = 1'b1;
      hold_n = 1'b0;
    end

    if (expired) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
      hold_n  = 1'b0;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SYNC) begin
            state_n = ST_ADDR_LO;
            hold_n  = 1'b1;
            err_n   = 1'b0;
            words_n = '0;
          end
        end
        ST_ADDR_LO: begin
          lo_byte_n = rx_data;
          state_n   = ST_ADDR_HI;
        end
        ST_ADDR_HI: begin
          cur_addr_n = field;
          state_n    = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          lo_byte_n = rx_data;
          state_n   = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          remaining_n = field;
          if (field == '0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          lo_byte_n = rx_data;
          state_n   = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          write_en_n  = 1'b1;
          addr_n      = cur_addr;
          datain_n    = {rx_data[N-9:0], lo_byte};
          cur_addr_n  = cur_addr + 1'b1;
          words_n     = words_written + 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == N'(1)) begin
            state_n    = ST_IDLE;
            fin_pend_n = 1'b1;
          end else begin
            state_n = ST_DATA_LO;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a byte-index frame model predicts every output
// each cycle, and literal checks pin the write log of each scenario.
module tb_mem_loader;

  localparam int N    = 12;
  localparam int TO   = 16;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         mem_write_en, hold, done, err;
  logic [N-1:0] mem_addr, mem_datain, words_written;

  mem_loader #(.N(N), .TIMEOUT(TO), .SYNC(8'hA5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .mem_write_en  (mem_write_en),
    .mem_addr      (mem_addr),
    .mem_datain    (mem_datain),
    .hold          (hold),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_in, m_fin;
  int m_pos, m_base, m_cnt, m_lo, m_idle;
  bit e_we, e_hold, e_done, e_err;
  int e_addr, e_data, e_ww;

  int wr_addr[$];
  int wr_data[$];
  int done_cnt = 0;
  logic [7:0] stim[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: tracks position within the frame by byte index.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in = 0; m_fin = 0; m_pos = 0; m_base = 0; m_cnt = 0; m_lo = 0; m_idle = 0;
      e_we = 0; e_hold = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0; e_ww = 0;
    end else begin
      e_we = 0;
      e_done = 0;
      if (m_fin) begin
        e_done = 1; e_hold = 0; m_fin = 0;
      end
      if (!m_in) begin
        if (rx_valid && rx_data == 8'hA5) begin
          m_in = 1; m_pos = 1; m_idle = 0;
          e_hold = 1; e_err = 0; e_ww = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        if (m_pos == 1 || m_pos == 3) begin
          m_lo = int'(rx_data);
        end else if (m_pos == 2) begin
          m_base = ((int'(rx_data) << 8) | m_lo) & MASK;
        end else if (m_pos == 4) begin
          m_cnt = ((int'(rx_data) << 8) | m_lo) & MASK;
          if (m_cnt == 0) begin
            m_in = 0; e_done = 1; e_hold = 0;
          end
        end else if (((m_pos - 5) % 2) == 0) begin
          m_lo = int'(rx_data);
        end else begin
          e_we = 1;
          e_addr = (m_base + (m_pos - 5) / 2) & MASK;
          e_data = ((int'(rx_data) << 8) | m_lo) & MASK;
          e_ww++;
          if ((m_pos - 5) / 2 + 1 == m_cnt) begin
            m_in = 0; m_fin = 1;
          end
        end
        m_pos++;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_in = 0; e_err = 1; e_hold = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("write_en", int'(mem_write_en), int'(e_we));
      chk("addr", int'(mem_addr), e_addr);
      chk("datain", int'(mem_datain), e_data);
      chk("hold", int'(hold), int'(e_hold));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      chk("words_written", int'(words_written), e_ww);
      if (mem_write_en) begin
        wr_addr.push_back(int'(mem_addr));
        wr_data.push_back(int'(mem_datain));
      end
      if (done) done_cnt++;
    end
  end

  task automatic play(input bit b2b);
    foreach (stim[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = stim[i];
      if (!b2b) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic chk_writes(input string nm, input int a0, input int d0, input int a1, input int d1);
    chk({nm, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk({nm, "_a0"}, wr_addr[0], a0);
      chk({nm, "_d0"}, wr_data[0], d0);
      chk({nm, "_a1"}, wr_addr[1], a1);
      chk({nm, "_d1"}, wr_data[1], d1);
    end
  endtask

  initial begin
    #1;
    chk("rst_we", int'(mem_write_en), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_ww", int'(words_written), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    clear_log();
    stim = '{8'hA5, 8'h04, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
    play(1'b0);
    repeat (3) @(negedge clk);
    chk_writes("basic", 4, 1, 5, 2);
    chk("basic_done", done_cnt, 1);
    chk("basic_ww", int'(words_written), 2);
    chk("basic_hold", int'(hold), 0);
    chk("basic_err", int'(err), 0);

    clear_log();
    stim = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
    play(1'b0);
    repeat (3) @(negedge clk);
    chk("zero_nwr", wr_addr.size(), 0);
    chk("zero_done", done_cnt, 1);
    chk("zero_hold", int'(hold), 0);

    clear_log();
    stim = '{8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'h34, 8'hF2, 8'h56, 8'h01};
    play(1'b0);
    repeat (3) @(negedge clk);
    chk_writes("wrap", 12'hFFF, 12'h234, 0, 12'h156);

    clear_log();
    stim = '{8'h00, 8'h13, 8'hA5, 8'h00, 8'h02, 8'h02, 8'h00, 8'hAA, 8'h0B, 8'hCC, 8'h0D};
    play(1'b1);
    repeat (3) @(negedge clk);
    chk_writes("b2b", 12'h200, 12'hBAA, 12'h201, 12'hDCC);
    chk("b2b_done", done_cnt, 1);

    clear_log();
    stim = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h77};
    play(1'b1);
    repeat (20) @(negedge clk);
    chk("to_err", int'(err), 1);
    chk("to_hold", int'(hold), 0);
    chk("to_nwr", wr_addr.size(), 0);
    chk("to_done", done_cnt, 0);
    stim = '{8'hA5};
    play(1'b0);
    chk("to_err_clr", int'(err), 0);
    chk("to_hold_new", int'(hold), 1);
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    play(1'b0);
    repeat (2) @(negedge clk);
    chk("to_next_done", done_cnt, 1);

    clear_log();
    stim = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    play(1'b1);
    chk("mid_hold_pre", int'(hold), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_hold", int'(hold), 0);
    chk("mid_we", int'(mem_write_en), 0);
    chk("mid_addr", int'(mem_addr), 0);
    chk("mid_datain", int'(mem_datain), 0);
    chk("mid_ww", int'(words_written), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    stim = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hEF, 8'h0C};
    play(1'b0);
    repeat (3) @(negedge clk);
    chk("post_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("post_a0", wr_addr[0], 12'h020);
      chk("post_d0", wr_data[0], 12'hCEF);
    end
    chk("post_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
